// File: rtl/imem_pkg.sv
// Shared definitions for the synchronous instruction memory fetch block:
// the NOP used as filler data, the 2-bit response error codes and the
// address fault classifier used by the top level.
package imem_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RANGE    = 2'b10,
      ERR_PARITY   = 2'b11
   } imem_err_t;

   // Alignment faults outrank range faults; clean addresses report ERR_OK.
   function automatic imem_err_t addr_fault(input logic misalign, input logic out_of_range);
      imem_err_t code;
      if (misalign) begin
         code = ERR_MISALIGN;
      end else if (out_of_range) begin
         code = ERR_RANGE;
      end else begin
         code = ERR_OK;
      end
      return code;
   endfunction

endpackage

// File: rtl/imem_sync_fetch_if.sv
// Fetch/response handshake and program-load bundle for imem_sync_fetch.
// master: PC/fetch side plus loader; slave: the instruction memory.
interface imem_sync_fetch_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 512,
   parameter int AW    = 32
);
   localparam int LAW = $clog2(DEPTH);

   logic            req_valid;
   logic            req_ready;
   logic [AW-1:0]   req_addr;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_data;
   logic [1:0]      rsp_err;
   logic            ld_en;
   logic [LAW-1:0]  ld_addr;
   logic [XLEN-1:0] ld_data;

   modport master (
      output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/imem_array.sv
// DEPTH x W storage: one synchronous write port, one synchronous read port
// with read enable. The read register only changes when rd_en is high, so
// a captured word survives later writes to the same location.
module imem_array #(
   parameter int DEPTH = 512,
   parameter int W     = 32,
   parameter int LAW   = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           wr_en,
   input  logic [LAW-1:0] wr_addr,
   input  logic [W-1:0]   wr_data,
   input  logic           rd_en,
   input  logic [LAW-1:0] rd_addr,
   output logic [W-1:0]   rd_data
);
   logic [W-1:0] mem_r [DEPTH];
   logic [W-1:0] rd_data_r;

   // Program-load write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read; holds its value between enabled reads.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data_r <= mem_r[rd_addr];
      end
   end

   assign rd_data = rd_data_r;
endmodule

// File: rtl/imem_sync_fetch.sv
// Synchronous-read instruction memory with valid/ready fetch handshake,
// one-entry response register, address fault reporting and a load port.
// Optional feature macro: IMEM_PARITY_EN adds an even-parity bit per word,
// checked on read (error code 11).
module imem_sync_fetch #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 512,
   parameter int AW    = 32
) (
   input logic               clk,
   input logic               rst_n,
   imem_sync_fetch_if.slave  bus
);
   import imem_pkg::*;

   localparam int LAW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
   localparam int MW = XLEN + 1;
`else
   localparam int MW = XLEN;
`endif

`ifdef IMEM_PARITY_EN
   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_parity(input logic [XLEN-1:0] word);
      return ^word;
   endfunction
`endif

   logic [AW-3:0]   word_idx_s;
   logic            misalign_s;
   logic            range_s;
   logic            ready_s;
   logic            accept_s;
   logic            rd_en_s;
   imem_err_t       err_s;
   logic [MW-1:0]   wr_word_s;
   logic [MW-1:0]   rd_word_s;
   logic [XLEN-1:0] rsp_data_s;
   imem_err_t       rsp_err_s;

   logic            rsp_valid_r;
   imem_err_t       err_r;
   logic            from_arr_r;

   // Byte address to word index; range check looks only at bits above the index.
   assign word_idx_s = bus.req_addr[AW-1:2];
   assign misalign_s = (bus.req_addr[1:0] != 2'b00);
   assign range_s    = ((word_idx_s >> LAW) != {(AW-2){1'b0}});
   assign err_s      = addr_fault(misalign_s, range_s);

   // Loads block fetches; a held response blocks until consumed.
   assign ready_s  = !bus.ld_en && (!rsp_valid_r || bus.rsp_ready);
   assign accept_s = bus.req_valid && ready_s;
   assign rd_en_s  = accept_s && (err_s == ERR_OK);

`ifdef IMEM_PARITY_EN
   assign wr_word_s = {even_parity(bus.ld_data), bus.ld_data};
`else
   assign wr_word_s = bus.ld_data;
`endif

   imem_array #(
      .DEPTH (DEPTH),
      .W     (MW),
      .LAW   (LAW)
   ) u_array (
      .clk     (clk),
      .wr_en   (bus.ld_en),
      .wr_addr (bus.ld_addr),
      .wr_data (wr_word_s),
      .rd_en   (rd_en_s),
      .rd_addr (word_idx_s[LAW-1:0]),
      .rd_data (rd_word_s)
   );

   // Response register: fill on accept, drain on consume, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= 1'b0;
         err_r       <= ERR_OK;
         from_arr_r  <= 1'b0;
      end else if (accept_s) begin
         rsp_valid_r <= 1'b1;
         err_r       <= err_s;
         from_arr_r  <= (err_s == ERR_OK);
      end else if (bus.rsp_ready) begin
         rsp_valid_r <= 1'b0;
      end else begin
         rsp_valid_r <= rsp_valid_r;
      end
   end

   // Select array word or NOP filler; in parity builds flag a stored-bit mismatch.
   always_comb begin
      rsp_data_s = XLEN'(NOP_INSTR);
      rsp_err_s  = err_r;
      if (from_arr_r) begin
         rsp_data_s = rd_word_s[XLEN-1:0];
`ifdef IMEM_PARITY_EN
         if (rd_word_s[XLEN] != even_parity(rd_word_s[XLEN-1:0])) begin
            rsp_err_s = ERR_PARITY;
         end else begin
            rsp_err_s = err_r;
         end
`endif
      end else begin
         rsp_data_s = XLEN'(NOP_INSTR);
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_s;
   assign bus.rsp_err   = rsp_err_s;
endmodule

// File: doc/imem_sync_fetch.md
Name: imem_sync_fetch

Overview:
- Parametrised, synchronous-read instruction memory for the RISC-V single-cycle core, evolving toward a pipelined fetch stage.
- Sits between the PC/fetch logic and the decoder.
- Adds word-aligned byte addressing, a valid/ready fetch handshake with a one-entry output register, fault reporting, and a program-load write port for bench/boot loading.

Parameters:
- XLEN, 32, instruction/data word width in bits.
- DEPTH, 512, number of instruction words stored; power of two, at least 2.
- AW, 32, width of the byte address on the fetch port.
- LAW, $clog2(DEPTH), word-index width on the load port (derived).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  fetch request accepted this cycle when high together with req_valid.
- req_addr  in  AW  byte address (PC).
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  XLEN  fetched instruction.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 parity (optional feature only).
- ld_en  in  1  program-load write strobe.
- ld_addr  in  LAW  word index to write.
- ld_data  in  XLEN  word to write.

Behaviour:
- Reset (async assert, sync-released use): rsp_valid=0, rsp_data=32'h00000013 (NOP, addi x0,x0,0), rsp_err=00. Array contents are not reset.
- Word index = req_addr >> 2. Byte addressing is never applied directly to the array.
- req_ready = !ld_en && (!rsp_valid || rsp_ready). Requests are blocked for every cycle ld_en is high.
- Accept (req_valid && req_ready): on the next edge rsp_valid=1, and rsp_data/rsp_err are loaded. Latency is exactly 1 cycle, so back-to-back accepts give one response per cycle.
- Response is consumed when rsp_valid && rsp_ready. If there is no new accept in that cycle, rsp_valid goes to 0 on the next edge.
- Stall (rsp_valid && !rsp_ready): rsp_data and rsp_err hold stable and req_ready=0.
- Misaligned (req_addr[1:0]!=0): rsp_err=01, rsp_data=NOP, no array read.
- Out of range (req_addr[AW-1:2] >= DEPTH): rsp_err=10, rsp_data=NOP. Misaligned takes priority over out of range.
- Load: when ld_en is high, the array word at ld_addr is written on the edge. No response is produced and no handshake is involved.
- Load while a response is held: the held rsp_data is unaffected (it was already captured). A request accepted on the cycle after a write to the same word returns the new data.
- A reset asserted mid-stall drops the pending response immediately: rsp_valid=0, with no partial data.

Optional Feature:
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed on load writes.
  - A read parity mismatch gives rsp_err=11 with rsp_data = raw stored word. Alignment and range errors take priority over parity.
- IMEM_PARITY_EN undefined:
  - No parity storage.
  - Code 11 is never produced.

Decomposition:
- Package imem_pkg holds:
  - NOP_INSTR constant (32'h00000013).
  - Error codes ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_PARITY as a 2-bit typedef imem_err_t.
- Sub-module imem_array: DEPTH x (XLEN[+1]) storage with one synchronous write port and one synchronous read port (read enable, registered output).
- The top level owns the handshake, fault decode, and response register.

Test Plan:
- Load words 0..3 with 002081B3, 403202B3, 00B6F663, 00B67763. Fetch addresses 0, 4, 8, 12 back-to-back with rsp_ready=1 -> same data in order, one per cycle, rsp_err=00, latency 1.
- Fetch 0x4, hold rsp_ready=0 for 3 cycles -> rsp_data stays 403202B3, req_ready=0 throughout. Release -> next request is accepted the same cycle.
- Fetch 0x6 -> rsp_err=01, data 00000013. Fetch 0x800 with DEPTH=512 -> rsp_err=10, data 00000013. Fetch 0x802 -> rsp_err=01.
- ld_en high with req_valid high -> req_ready=0, no response. Write word 5=001122B3, then fetch 0x14 the next cycle -> 001122B3.
- rst_n low during a held response -> rsp_valid=0 and rsp_data=00000013 immediately, with no clock edge needed. Array contents are intact after release.
- With IMEM_PARITY_EN, force a flipped bit in word 2 via backdoor and fetch 0x8 -> rsp_err=11. Without the macro, the same fetch returns corrupted data with rsp_err=00.
